mac_vector_sequencer: RTL and testbench
=======================================

// Module: mac_vector_sequencer
// PURPOSE
//  Upstream/downstream control stage wrapped around one mac_cell (1-cycle registered
//  acc_out = a*b + acc_in). Accepts a dot-product command (length, bias) plus a
//  valid/ready stream of (a,b) operand pairs. Drives the mac_cell and feeds acc_out
//  back to acc_in each cycle. Returns the final accumulator on a valid/ready result port.
// PARAMETERS
//  DATA_W  16  operand width (must match mac_cell a/b)
//  ACC_W   32  accumulator width (must match mac_cell acc_in/acc_out)
//  LEN_W   8   width of cmd_len; max vector length 2**LEN_W-1
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       command accepted when cmd_valid & cmd_ready
//  cmd_len      in   LEN_W   number of (a,b) pairs in the vector
//  cmd_bias     in   ACC_W   initial accumulator value
//  in_valid     in   1       operand pair offered
//  in_ready     out  1       pair consumed ("issue") when in_valid & in_ready
//  in_a, in_b   in   DATA_W  operand pair
//  mac_a/mac_b  out  DATA_W  to mac_cell a/b
//  mac_acc_in   out  ACC_W   to mac_cell acc_in
//  mac_acc_out  in   ACC_W   from mac_cell acc_out
//  res_valid    out  1       result held valid
//  res_ready    in   1       result consumed when res_valid & res_ready
//  res_data     out  ACC_W   final accumulator (registered)
// BEHAVIOUR
//  - States: IDLE, RUN, DRAIN, DONE. Reset (async, rst_n=0) forces IDLE.
//    Reset values: remaining=0, first=0, res_data=0, res_valid=0, in_ready=0, cmd_ready=1.
//  - cmd_ready = (state==IDLE); in_ready = (state==RUN); res_valid = (state==DONE).
//  - IDLE: on cmd handshake, latch bias.
//    * If cmd_len==0: res_data<=cmd_bias, go to DONE.
//    * Else: remaining<=cmd_len, first<=1, go to RUN.
//  - RUN, issue cycle:
//    * mac_a=in_a, mac_b=in_b.
//    * mac_acc_in = first ? bias_reg : mac_acc_out.
//    * first<=0, remaining<=remaining-1.
//    * If remaining==1, go to DRAIN.
//  - RUN, no issue (bubble): mac_a=mac_b=0 and mac_acc_in=mac_acc_out, so the
//    accumulator is held. Exception: while first==1, mac_acc_in=bias_reg.
//    Bubbles of any length must not change the final result.
//  - Outside RUN: mac_a=mac_b=0, mac_acc_in=mac_acc_out (hold).
//  - DRAIN: exactly one cycle, absorbs mac_cell latency.
//    res_data<=mac_acc_out, go to DONE.
//  - DONE: res_data/res_valid held stable while res_ready=0.
//    On handshake go to IDLE; the next command can be accepted the cycle after.
//  - Latency: last issue at cycle N -> DRAIN at N+1 -> res_valid high from N+2.
//    len==0: res_valid high the cycle after the cmd handshake.
//  - Arithmetic is unsigned; wrap mod 2**ACC_W is performed by mac_cell.
//    The sequencer never alters the data.
//  - mac_a/mac_b/mac_acc_in are combinational from state and inputs; all other
//    outputs are decoded from registered state.
//  - Reset asserted mid-RUN/DRAIN/DONE:
//    * abandons the vector; no res_valid is produced;
//    * operand pairs not yet issued remain in the upstream source;
//    * cmd_ready=1 immediately after reset releases.
//  - cmd_valid outside IDLE is ignored (not accepted). in_valid outside RUN is
//    ignored (never consumed).
// TESTING
//  - len=1, bias=10, pair (3,4) -> res_data=22, res_valid 2 cycles after issue.
//  - len=2, bias=10, pairs (3,4),(2,5) back-to-back -> res_data=32.
//  - len=2, bias=10, same pairs with 3 in_valid=0 bubbles between -> res_data=32,
//    mac_acc_out constant during bubbles.
//  - len=0, bias=7 -> res_valid next cycle, res_data=7, in_ready never high.
//  - len=1, bias=0xFFFFFFFF, pair (0xFFFF,0xFFFF) -> res_data=0xFFFE0000 (wrap).
//  - res_ready=0 for 5 cycles in DONE -> res_data/res_valid stable, cmd_ready=0.
//    Then pulse res_ready -> IDLE.
//  - rst_n low mid-RUN of len=4 after 2 issues -> IDLE, res_valid=0.
//    A following len=1 (3,4), bias=10 -> 22.

Source files
------------

// File: rtl/mac_vector_sequencer.sv
// mac_vector_sequencer: drives one external 1-cycle mac_cell through a
// dot product, feeding acc_out back to acc_in and returning the final sum.
module mac_vector_sequencer #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ACC_W-1:0]  cmd_bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic [ACC_W-1:0]  mac_acc_in,
  input  logic [ACC_W-1:0]  mac_acc_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] remaining;
  logic             first;
  logic [ACC_W-1:0] bias_reg;
  logic             cmd_fire;
  logic             issue;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign issue    = in_valid & in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs, decoded from the registered state
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = (cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && remaining == LEN_W'(1)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command latch, issue bookkeeping and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      first     <= 1'b0;
      bias_reg  <= '0;
      res_data  <= '0;
    end else begin
      if (cmd_fire) begin
        bias_reg <= cmd_bias;
        if (cmd_len == '0) begin
          res_data <= cmd_bias;
        end else begin
          remaining <= cmd_len;
          first     <= 1'b1;
        end
      end
      if (issue) begin
        first     <= 1'b0;
        remaining <= remaining - LEN_W'(1);
      end
      if (state == DRAIN) begin
        res_data <= mac_acc_out;
      end
    end
  end

  // mac_cell drive: zero operands and recirculate the sum unless issuing;
  // bias seeds the accumulator until the first pair has gone in
  always_comb begin
    mac_a      = '0;
    mac_b      = '0;
    mac_acc_in = mac_acc_out;
    unique case (1'b1)
      (state == RUN && first): begin
        mac_acc_in = bias_reg;
        if (issue) begin
          mac_a = in_a;
          mac_b = in_b;
        end
      end
      (state == RUN && !first): begin
        if (issue) begin
          mac_a = in_a;
          mac_b = in_b;
        end
      end
      default: begin
        mac_a = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_vector_sequencer.sv
// tb_mac_vector_sequencer: directed and randomized dot products against
// a plain-arithmetic reference, with a behavioural mac_cell stand-in.
module tb_mac_vector_sequencer;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic [AW-1:0] cmd_bias = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [AW-1:0] mac_acc_in;
  logic [AW-1:0] mac_acc_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [AW-1:0] res_data;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] pa [0:255];
  logic [DW-1:0] pb [0:255];

  logic [AW-1:0] r_res;
  int            r_lat;
  bit            r_moved;
  bit            r_to;
  bit            r_inrdy;

  mac_vector_sequencer #(
    .DATA_W(DW),
    .ACC_W(AW),
    .LEN_W(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len(cmd_len),
    .cmd_bias(cmd_bias),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .mac_a(mac_a),
    .mac_b(mac_b),
    .mac_acc_in(mac_acc_in),
    .mac_acc_out(mac_acc_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mac_acc_out <= '0;
    else mac_acc_out <= (AW'(mac_a) * AW'(mac_b)) + mac_acc_in;
  end

  function automatic logic [AW-1:0] dot(input int len, input logic [AW-1:0] bias);
    longint unsigned s;
    s = 64'(bias);
    for (int i = 0; i < len; i++) s += 64'(pa[i]) * 64'(pb[i]);
    return s[AW-1:0];
  endfunction

  task automatic run_vector(input int len, input logic [AW-1:0] bias,
                            input int bub, input bit rnd);
    int waitc;
    int nb;
    logic [AW-1:0] hold;
    r_to = 0; r_moved = 0; r_inrdy = 0; r_lat = 0; r_res = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = LW'(len); cmd_bias = bias;
    waitc = 0;
    while (!cmd_ready && waitc < 50) begin @(negedge clk); waitc++; end
    if (!cmd_ready) begin r_to = 1; cmd_valid = 1'b0; return; end
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      nb = rnd ? int'($urandom_range(bub, 0)) : bub;
      if (i > 0) begin
        hold = mac_acc_out;
        in_valid = 1'b0;
        for (int k = 0; k < nb; k++) begin
          @(negedge clk);
          if (mac_acc_out !== hold) r_moved = 1;
        end
      end
      in_valid = 1'b1; in_a = pa[i]; in_b = pb[i];
      waitc = 0;
      while (!in_ready && waitc < 50) begin @(negedge clk); waitc++; end
      if (!in_ready) begin r_to = 1; in_valid = 1'b0; return; end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; in_a = '0; in_b = '0;
    waitc = 0;
    if (in_ready) r_inrdy = 1;
    while (!res_valid && waitc < 50) begin
      @(negedge clk); waitc++;
      if (in_ready) r_inrdy = 1;
    end
    if (!res_valid) begin r_to = 1; return; end
    r_lat = waitc + 1;
    r_res = res_data;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
    else passed++;
    total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready);
    else passed++;
    total++;
    if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %b want 0", res_valid);
    else passed++;
    total++;
    if (res_data !== '0) $display("FAIL reset_res_data got %h want 0", res_data);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    pa[0] = 16'd3; pb[0] = 16'd4;
    run_vector(1, 32'd10, 0, 0);
    total++;
    if (r_to || r_res !== 32'd22) $display("FAIL single_res got %0d (to=%0b) want 22", r_res, r_to);
    else passed++;
    total++;
    if (r_lat !== 2) $display("FAIL single_latency got %0d want 2", r_lat);
    else passed++;
    consume();
    total++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0)
      $display("FAIL single_back_idle got rdy=%b vld=%b want 1/0", cmd_ready, res_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    pa[0] = 16'd3; pb[0] = 16'd4; pa[1] = 16'd2; pb[1] = 16'd5;
    run_vector(2, 32'd10, 0, 0);
    total++;
    if (r_to || r_res !== 32'd32) $display("FAIL b2b_res got %0d want 32", r_res);
    else passed++;
    total++;
    if (r_lat !== 2) $display("FAIL b2b_latency got %0d want 2", r_lat);
    else passed++;
    consume();
  endtask

  task automatic test_bubbles();
    pa[0] = 16'd3; pb[0] = 16'd4; pa[1] = 16'd2; pb[1] = 16'd5;
    run_vector(2, 32'd10, 3, 0);
    total++;
    if (r_to || r_res !== 32'd32) $display("FAIL bubble_res got %0d want 32", r_res);
    else passed++;
    total++;
    if (r_moved !== 1'b0) $display("FAIL bubble_acc_hold got moved=%0b want 0", r_moved);
    else passed++;
    consume();
  endtask

  task automatic test_len0();
    run_vector(0, 32'd7, 0, 0);
    total++;
    if (r_to || r_res !== 32'd7) $display("FAIL len0_res got %0d want 7", r_res);
    else passed++;
    total++;
    if (r_lat !== 1) $display("FAIL len0_latency got %0d want 1", r_lat);
    else passed++;
    total++;
    if (r_inrdy !== 1'b0) $display("FAIL len0_in_ready got %0b want 0", r_inrdy);
    else passed++;
    consume();
  endtask

  task automatic test_wrap();
    pa[0] = 16'hFFFF; pb[0] = 16'hFFFF;
    run_vector(1, 32'hFFFF_FFFF, 0, 0);
    total++;
    if (r_to || r_res !== 32'hFFFE_0000) $display("FAIL wrap_res got %h want fffe0000", r_res);
    else passed++;
    consume();
  endtask

  task automatic test_stall();
    logic [AW-1:0] exp;
    bit bad;
    pa[0] = DW'($urandom); pb[0] = DW'($urandom);
    pa[1] = DW'($urandom); pb[1] = DW'($urandom);
    exp = dot(2, 32'h1234_5678);
    run_vector(2, 32'h1234_5678, 0, 0);
    cmd_valid = 1'b1; cmd_len = 8'd0; in_valid = 1'b1;
    bad = r_to;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== exp || cmd_ready !== 1'b0 || in_ready !== 1'b0)
        bad = 1;
    end
    total++;
    if (bad) $display("FAIL stall_hold got vld=%b data=%h crdy=%b want 1/%h/0",
                      res_valid, res_data, cmd_ready, exp);
    else passed++;
    cmd_valid = 1'b0; in_valid = 1'b0;
    consume();
    total++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL stall_release got vld=%b crdy=%b want 0/1", res_valid, cmd_ready);
    else passed++;
  endtask

  task automatic test_mid_reset();
    bit bad;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 8'd4; cmd_bias = 32'd99;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = DW'(i + 5); in_b = DW'(i + 6);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL midrst_async got crdy=%b vld=%b irdy=%b want 1/0/0",
               cmd_ready, res_valid, in_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) bad = 1;
    end
    total++;
    if (bad) $display("FAIL midrst_no_result got vld=%b crdy=%b want 0/1", res_valid, cmd_ready);
    else passed++;
    pa[0] = 16'd3; pb[0] = 16'd4;
    run_vector(1, 32'd10, 0, 0);
    total++;
    if (r_to || r_res !== 32'd22) $display("FAIL midrst_after got %0d want 22", r_res);
    else passed++;
    consume();
  endtask

  task automatic test_random();
    int len;
    logic [AW-1:0] bias;
    logic [AW-1:0] exp;
    for (int t = 0; t < 25; t++) begin
      len = (t % 7 == 3) ? 0 : int'($urandom_range(12, 1));
      bias = AW'($urandom);
      for (int i = 0; i < len; i++) begin
        pa[i] = DW'($urandom); pb[i] = DW'($urandom);
      end
      exp = dot(len, bias);
      run_vector(len, bias, 3, 1);
      total++;
      if (r_to || r_res !== exp)
        $display("FAIL random_%0d len=%0d got %h (to=%0b) want %h", t, len, r_res, r_to, exp);
      else passed++;
      for (int k = int'($urandom_range(3, 0)); k > 0; k--) @(negedge clk);
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bubbles();
    test_len0();
    test_wrap();
    test_stall();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
